// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer and the requester FSMs that drive its sel/ld handshake.
package timer_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] ch_t;

  localparam logic [NUM_CH-1:0] SEL_NULL = 4'b0000;
  localparam logic [NUM_CH-1:0] SEL_T0   = 4'b0001;
  localparam logic [NUM_CH-1:0] SEL_T1   = 4'b0010;
  localparam logic [NUM_CH-1:0] SEL_T2   = 4'b0100;
  localparam logic [NUM_CH-1:0] SEL_T3   = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Lowest set bit wins; callers only use the result when sel is non-zero.
  function automatic ch_t sel_to_ch(input logic [NUM_CH-1:0] sel);
    if (sel[0]) begin
      return 2'd0;
    end else if (sel[1]) begin
      return 2'd1;
    end else if (sel[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every PRESCALE enabled cycles; clr forces the count to 0.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/interval_timer.sv
// Shared interval timer: a load starts one of four programmed intervals, counted in prescaled
// ticks; expiry returns a one-cycle pulse on the matching bit of T.
module interval_timer
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned LEN0     = 5,
  parameter int unsigned LEN1     = 10,
  parameter int unsigned LEN2     = 15,
  parameter int unsigned LEN3     = 30,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic [NUM_CH-1:0] sel,
  output logic [NUM_CH-1:0] T,
  output logic              busy,
  output logic [CNT_W-1:0]  remaining
);

  localparam int unsigned LENS [NUM_CH] = '{LEN0, LEN1, LEN2, LEN3};

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("interval_timer: PRESCALE must be >= 1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_len_check
    if (LENS[i] < 1 || LENS[i] > (2 ** CNT_W) - 1) begin : g_bad_len
      $error("interval_timer: interval length out of range for CNT_W");
    end
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  ch_t                 channel_q, channel_d;
  logic [NUM_CH-1:0]   t_q, t_d;
  logic                load;
  ch_t                 load_ch;
  logic                tick;

  assign load    = ld && (sel != SEL_NULL);
  assign load_ch = sel_to_ch(sel);

  // Prescaler sits at 0 outside RUN and restarts on every load, so the first tick is a full one.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_tick_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (load || (state_q != RUN)),
    .en    (state_q == RUN),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    channel_d   = channel_q;
    t_d         = '0;
    if (load) begin
      // A load on the expiry edge takes priority and suppresses the old pulse.
      state_d     = RUN;
      channel_d   = load_ch;
      remaining_d = CNT_W'(LENS[load_ch]);
    end else if (state_q == RUN && tick) begin
      if (remaining_q > CNT_W'(1)) begin
        remaining_d = remaining_q - CNT_W'(1);
      end else begin
        remaining_d    = '0;
        state_d        = IDLE;
        t_d[channel_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      channel_q   <= '0;
      t_q         <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      channel_q   <= channel_d;
      t_q         <= t_d;
    end
  end

  assign T         = t_q;
  assign busy      = (state_q == RUN);
  assign remaining = remaining_q;

endmodule

// File: tb/tb_interval_timer.sv
// Drives two interval_timer instances (PRESCALE 4 and 1) with shared stimulus and checks each
// against a deadline-based reference model.
module tb_interval_timer;
  import timer_pkg::*;

  localparam int unsigned CW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] t_a, t_b;
  logic              busy_a, busy_b;
  logic [CW-1:0]     rem_a, rem_b;

  always #5 clk = ~clk;

  interval_timer #(
    .PRESCALE (4), .LEN0 (2), .LEN1 (3), .LEN2 (1), .LEN3 (5), .CNT_W (CW)
  ) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .ld        (ld),
    .sel       (sel),
    .T         (t_a),
    .busy      (busy_a),
    .remaining (rem_a)
  );

  interval_timer #(
    .PRESCALE (1), .LEN0 (2), .LEN1 (3), .LEN2 (1), .LEN3 (5), .CNT_W (CW)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .ld        (ld),
    .sel       (sel),
    .T         (t_b),
    .busy      (busy_b),
    .remaining (rem_b)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: an active interval is just a channel plus the edge number it expires on.
  int          pre [2]  = '{4, 1};
  int          lens [4] = '{2, 3, 1, 5};
  bit          m_active [2];
  int          m_ch [2];
  int          m_deadline [2];
  logic [3:0]  m_t [2];
  int          m_now = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at edge %0d: got %0h, expected %0h", tag, m_now, obs, exp);
  endtask

  function automatic int lowest(input logic [3:0] s);
    for (int i = 0; i < 4; i++) begin
      if (s[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_t[i]      = 4'b0000;
    end
  endtask

  task automatic model_edge();
    int c;
    m_now++;
    c = ld ? lowest(sel) : -1;
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 4'b0000;
      if (c >= 0) begin
        m_active[i]   = 1'b1;
        m_ch[i]       = c;
        m_deadline[i] = m_now + lens[c] * pre[i];
      end else if (m_active[i] && m_now == m_deadline[i]) begin
        m_t[i]      = 4'b0001 << m_ch[i];
        m_active[i] = 1'b0;
      end
    end
  endtask

  function automatic int exp_rem(input int i);
    if (!m_active[i]) return 0;
    return (m_deadline[i] - m_now + pre[i] - 1) / pre[i];
  endfunction

  task automatic check_all();
    check("T_p4", 32'(t_a), 32'(m_t[0]));
    check("busy_p4", 32'(busy_a), 32'(m_active[0]));
    check("remaining_p4", 32'(rem_a), 32'(exp_rem(0)));
    check("T_p1", 32'(t_b), 32'(m_t[1]));
    check("busy_p1", 32'(busy_b), 32'(m_active[1]));
    check("remaining_p1", 32'(rem_b), 32'(exp_rem(1)));
  endtask

  task automatic step(input logic l, input logic [3:0] s);
    ld  = l;
    sel = s;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'b0000);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_mid();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ld    = 1'b0;
    sel   = 4'b0000;
    model_reset();
    #3;
    check_all();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all();

    // Basic T1
    step(1'b1, SEL_T1);
    idle(14);
    // Minimum interval
    step(1'b1, SEL_T2);
    idle(6);
    step(1'b1, SEL_T0);
    idle(10);
    // Abort and reload
    step(1'b1, SEL_T3);
    idle(5);
    step(1'b1, SEL_T0);
    idle(10);
    // Load on the expiry edge
    step(1'b1, SEL_T0);
    idle(7);
    step(1'b1, SEL_T1);
    idle(14);
    // Bad and multi-hot selects
    step(1'b1, SEL_NULL);
    idle(3);
    step(1'b1, 4'b0110);
    idle(14);
    // Held ld re-arms each cycle
    step(1'b1, SEL_T0);
    step(1'b1, SEL_T0);
    step(1'b1, SEL_T2);
    idle(8);
    // Reset in the middle of a T3 interval
    step(1'b1, SEL_T3);
    idle(4);
    reset_mid();
    idle(25);

    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) == 0) reset_mid();
      step(($urandom_range(0, 7) == 0), 4'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
